// File: rtl/ring_token_scheduler_pkg.sv
// Shared constants for the ring token scheduler: FSM state encoding and
// default parameter values used by the top and the tick prescaler.
package ring_token_scheduler_pkg;

  // Default number of requesters sharing the resource
  localparam int N_DEFAULT        = 8;
  // Default clock cycles per tick
  localparam int DIV_DEFAULT      = 100;
  // Default number of ticks a grant may be held before it is revoked
  localparam int MAX_HOLD_DEFAULT = 4;

  // Scheduler FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/ring_token_scheduler_tick_prescaler.sv
// Tick prescaler: free-running modulo-DIV counter that advances only while
// enabled and flags the last count of each period as a single-cycle tick.
module tick_prescaler
  import ring_token_scheduler_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          wrap;

  assign wrap = (pcnt_q == PCNT_LAST);

  // Tick is combinational on the final count so it is high in exactly that
  // cycle, and is suppressed whenever the prescaler is frozen.
  assign tick_o = enable_i & wrap;

  // Next count: hold when disabled, wrap to zero after the last count
  always_comb begin
    pcnt_d = pcnt_q;
    if (enable_i) begin
      pcnt_d = wrap ? '0 : pcnt_q + PW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/ring_token_scheduler.sv
// Round-robin scheduler sharing one resource among N requesters with a
// one-hot token ring. The token marks where the next search starts; after a
// grant ends the token moves just past the holder so it is searched last.
module ring_token_scheduler
  import ring_token_scheduler_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int DIV      = DIV_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic         clk_100Mhz_i,
  input  logic         reset_ni,
  input  logic         enable_i,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] release_i,
  output logic [N-1:0] grant_o,
  output logic [N-1:0] token_o,
  output logic         tick_o,
  output logic         busy_o,
  output logic         timeout_o
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int N2 = 2 * N;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [0:0]    state_q,   state_d;
  logic [N-1:0]  grant_q,   grant_d;
  logic [N-1:0]  token_q,   token_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic          timeout_q, timeout_d;

  logic          tick;
  logic [N-1:0]  token_rotl;
  logic [N-1:0]  grant_rotl;
  logic [N-1:0]  mask_ge;
  logic [N2-1:0] dbl;
  logic [N2-1:0] dbl_iso;
  logic [N-1:0]  pick;
  logic          holder_release;
  logic          holder_dropped;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk_i    (clk_100Mhz_i),
    .rst_ni   (reset_ni),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  // Rotate-left by one position, bit N-1 wrapping back to bit 0
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_rot
    assign token_rotl[(gi + 1) % N] = token_q[gi];
    assign grant_rotl[(gi + 1) % N] = grant_q[gi];
  end

  // Circular priority search starting at the token. The lower half keeps
  // only requests at or above the token; the upper half is the full request
  // vector, so the lowest set bit of the concatenation is the first request
  // found going upward from the token with wrap-around.
  assign mask_ge = ~(token_q - N'(1));
  assign dbl     = {req_i, req_i & mask_ge};
  assign dbl_iso = dbl & (~dbl + N2'(1));
  assign pick    = dbl_iso[N-1:0] | dbl_iso[N2-1:N];

  // Only the current holder's release/request bits matter
  assign holder_release = |(release_i & grant_q);
  assign holder_dropped = ~|(req_i & grant_q);

  // FSM next-state: issue grants from IDLE, end them on release, on request
  // withdrawal or on hold timeout; release has priority over timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    token_d   = token_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == ST_GRANT) begin
      if (holder_release || holder_dropped) begin
        grant_d = '0;
        token_d = grant_rotl;
        hold_d  = '0;
        state_d = ST_IDLE;
      end else if (tick) begin
        if (hold_q == HOLD_LAST) begin
          grant_d   = '0;
          token_d   = grant_rotl;
          hold_d    = '0;
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end else begin
      if (enable_i && (|req_i)) begin
        grant_d = pick;
        token_d = pick;
        hold_d  = '0;
        state_d = ST_GRANT;
      end else if (tick) begin
        token_d = token_rotl;
      end
    end
  end

  // State registers; reset parks the token on requester 0 with no grant
  always_ff @(posedge clk_100Mhz_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      token_q   <= N'(1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      token_q   <= token_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign token_o   = token_q;
  assign tick_o    = tick;
  assign busy_o    = (state_q == ST_GRANT);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_ring_token_scheduler.sv
// Scoreboard bench for ring_token_scheduler (N=8, DIV=4, MAX_HOLD=4).
// Stimulus pushes expected output changes (with the cycle gap since the
// previous change) into a queue; a monitor pops one entry per observed change.
module tb_ring_token_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] rel = '0;
  logic [7:0] grant;
  logic [7:0] token;
  logic       tick;
  logic       busy;
  logic       timeout;

  ring_token_scheduler #(
    .N        (8),
    .DIV      (4),
    .MAX_HOLD (4)
  ) dut (
    .clk_100Mhz_i (clk),
    .reset_ni     (reset_n),
    .enable_i     (enable),
    .req_i        (req),
    .release_i    (rel),
    .grant_o      (grant),
    .token_o      (token),
    .tick_o       (tick),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] grant;
    logic [7:0] token;
    logic       timeout;
    logic       busy;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dwell;   // cycles since previous change, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [7:0] g, input logic [7:0] t,
                          input logic to, input logic b, input int d);
    exp_t e;
    e.s.grant   = g;
    e.s.token   = t;
    e.s.timeout = to;
    e.s.busy    = b;
    e.dwell     = d;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    snap_t prev;
    snap_t cur;
    int    cnt;
    bit    was_en;
    exp_t  e;
    prev   = '0;
    cnt    = 0;
    was_en = 1'b0;
    forever begin
      @(negedge clk);
      cur.grant   = grant;
      cur.token   = token;
      cur.timeout = timeout;
      cur.busy    = busy;
      if (mon_en) begin
        if (!was_en) begin
          prev = cur;
          cnt  = 1;
        end else begin
          cnt++;
          if (cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL unexpected_event: got grant=%h token=%h timeout=%b busy=%b dwell=%0d, required no change",
                       cur.grant, cur.token, cur.timeout, cur.busy, cnt);
            end else begin
              e = exp_q.pop_front();
              if ((cur !== e.s) || ((e.dwell >= 0) && (cnt != e.dwell))) begin
                n_bad++;
                $display("FAIL event: got grant=%h token=%h timeout=%b busy=%b dwell=%0d, required grant=%h token=%h timeout=%b busy=%b dwell=%0d",
                         cur.grant, cur.token, cur.timeout, cur.busy, cnt,
                         e.s.grant, e.s.token, e.s.timeout, e.s.busy, e.dwell);
              end else begin
                $display("ok   event: grant=%h token=%h timeout=%b busy=%b dwell=%0d",
                         cur.grant, cur.token, cur.timeout, cur.busy, cnt);
              end
            end
            prev = cur;
            cnt  = 0;
          end
        end
      end
      was_en = mon_en;
    end
  endtask

  // Reset pulse; returns one time unit after the posedge that precedes
  // reset release, with the monitor re-armed.
  task automatic do_reset();
    mon_en  = 1'b0;
    enable  = 1'b0;
    req     = '0;
    rel     = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] t;
    fork
      monitor_loop();
    join_none

    // Reset values while reset is held
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_token",   token,   8'h01);
    chk("reset_grant",   grant,   8'h00);
    chk("reset_busy",    busy,    1'b0);
    chk("reset_tick",    tick,    1'b0);
    chk("reset_timeout", timeout, 1'b0);

    // Idle rotation and first tick position
    do_reset();
    enable = 1'b1;
    t = 8'h02;
    push_exp(8'h00, t, 1'b0, 1'b0, 5);
    repeat (7) begin
      t = {t[6:0], t[7]};
      push_exp(8'h00, t, 1'b0, 1'b0, 4);
    end
    repeat (3) @(negedge clk);
    chk("tick_before_div", tick, 1'b0);
    @(negedge clk);
    chk("tick_at_div", tick, 1'b1);
    @(negedge clk);
    chk("tick_single_cycle", tick, 1'b0);
    repeat (28) @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;

    // Fairness: requesters 0 and 7 alternate
    do_reset();
    push_exp(8'h01, 8'h01, 1'b0, 1'b1, 2);
    push_exp(8'h00, 8'h02, 1'b0, 1'b0, 2);
    push_exp(8'h80, 8'h80, 1'b0, 1'b1, 1);
    push_exp(8'h00, 8'h01, 1'b0, 1'b0, 1);
    push_exp(8'h01, 8'h01, 1'b0, 1'b1, 1);
    push_exp(8'h00, 8'h02, 1'b0, 1'b0, 1);
    enable = 1'b1;
    req    = 8'h81;
    repeat (2) @(posedge clk); #1; rel = 8'h01;
    @(posedge clk); #1; rel = 8'h00;
    @(posedge clk); #1; rel = 8'h80;
    @(posedge clk); #1; rel = 8'h00;
    @(posedge clk); #1; rel = 8'h01;
    @(posedge clk); #1; rel = 8'h00; req = 8'h00; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Hold timeout with a foreign release pulse that must be ignored
    do_reset();
    push_exp(8'h08, 8'h08, 1'b0, 1'b1, 2);
    push_exp(8'h00, 8'h10, 1'b1, 1'b0, 15);
    push_exp(8'h00, 8'h10, 1'b0, 1'b0, 1);
    enable = 1'b1;
    req    = 8'h08;
    repeat (5) @(posedge clk); #1; rel = 8'h04;
    @(posedge clk); #1; rel = 8'h00;
    repeat (10) @(posedge clk); #1; req = 8'h00; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Release on the final hold tick: release wins, no timeout pulse
    do_reset();
    push_exp(8'h08, 8'h08, 1'b0, 1'b1, 2);
    push_exp(8'h00, 8'h10, 1'b0, 1'b0, 15);
    enable = 1'b1;
    req    = 8'h08;
    repeat (15) @(posedge clk); #1; rel = 8'h08;
    @(posedge clk); #1; rel = 8'h00; req = 8'h00; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-grant, enable gating, request withdrawal
    do_reset();
    push_exp(8'h04, 8'h04, 1'b0, 1'b1, 2);
    push_exp(8'h00, 8'h01, 1'b0, 1'b0, 1);
    push_exp(8'h04, 8'h04, 1'b0, 1'b1, -1);
    push_exp(8'h00, 8'h08, 1'b0, 1'b0, 1);
    enable = 1'b1;
    req    = 8'h04;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_grant", grant, 8'h04);
    reset_n = 1'b0;
    #1;
    chk("async_reset_grant", grant, 8'h00);
    chk("async_reset_token", token, 8'h01);
    chk("async_reset_busy",  busy,  1'b0);
    enable = 1'b0;
    repeat (2) @(posedge clk); #1; reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("disabled_no_grant", grant, 8'h00);
    chk("disabled_not_busy", busy,  1'b0);
    enable = 1'b1;
    @(posedge clk); #1; req = 8'h00;
    @(posedge clk); #1; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
